// File: rtl/sipo_piso_pkg.sv
// Shared definitions for the 16-bit serial shift link (PISO transmitter / SIPO receiver).
package sipo_piso_pkg;
  localparam int LINK_WIDTH = 16;
  localparam int CNT_W      = $clog2(LINK_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register that presents one end as bit_out and shifts zeros in from the other end.
module piso_shift_reg #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) data_q <= {data_q[WIDTH-2:0], 1'b0};
      else                data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign bit_out = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];
endmodule

// File: rtl/piso_16bit_tx.sv
// Parallel-in/serial-out transmitter: accepts one word per handshake and sends it one bit per clock.
module piso_16bit_tx
  import sipo_piso_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done,
  output state_t           state
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  logic [CW-1:0] cnt;
  logic          accept;
  logic          bit_out;

  // Handshake: a word transfers on a rising edge where load_valid && load_ready.
  // load_ready depends only on registered state and reset, never on load_valid,
  // and is high in IDLE or on the last bit of a frame so frames can abut.
  assign load_ready = !reset && ((state == IDLE) || (cnt == LAST));
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      done         <= 1'b0;
    end else if (accept) begin
      state        <= SHIFT;
      cnt          <= '0;
      serial_valid <= 1'b1;
      frame_start  <= 1'b1;
      done         <= 1'b0;
    end else if (state == SHIFT) begin
      frame_start <= 1'b0;
      if (cnt == LAST) begin
        state        <= IDLE;
        cnt          <= '0;
        serial_valid <= 1'b0;
        done         <= 1'b0;
      end else begin
        cnt  <= cnt + 1'b1;
        done <= (cnt == PRE_LAST);
      end
    end else begin
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      done         <= 1'b0;
    end
  end

  // A full frame shifts in WIDTH zeros, so the register is already clear in IDLE.
  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift_en (state == SHIFT),
    .data     (load_data),
    .bit_out  (bit_out)
  );

  assign serial_out = bit_out && serial_valid;
endmodule

// File: tb/tb_piso_16bit_tx.sv
// Randomized self-checking bench for piso_16bit_tx in MSB-first and LSB-first configurations.
module tb_piso_16bit_tx;
  import sipo_piso_pkg::*;

  localparam int W = LINK_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready, serial_out, serial_valid, frame_start, done;
  state_t       state;

  logic [W-1:0] lsb_data;
  logic         lsb_valid;
  logic         lsb_ready, lsb_out, lsb_svalid, lsb_start, lsb_done;
  state_t       lsb_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_16bit_tx #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out), .serial_valid(serial_valid),
    .frame_start(frame_start), .done(done), .state(state)
  );

  piso_16bit_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .load_data(lsb_data), .load_valid(lsb_valid),
    .load_ready(lsb_ready), .serial_out(lsb_out), .serial_valid(lsb_svalid),
    .frame_start(lsb_start), .done(lsb_done), .state(lsb_state)
  );

  // Reference: the bit a link carries at position i of a frame of word w.
  function automatic logic ref_bit(logic [W-1:0] w, int i, bit msb_first);
    return msb_first ? w[W-1-i] : w[i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0; lsb_valid = 1'b0; lsb_data = '0;
    step(); step();
    checks++;
    if ({serial_out, serial_valid, frame_start, done, load_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {serial_out, serial_valid, frame_start, done, load_ready});
    end
    checks++;
    if (state !== IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1 || lsb_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset got=%b%b exp=11", load_ready, lsb_ready);
    end
  endtask

  task automatic test_single_frame(input logic [W-1:0] w);
    logic [W-1:0] sipo;
    logic [4:0]   exp_v;
    sipo = '0;
    load_data = w; load_valid = 1'b1;
    step();
    load_valid = 1'b0; load_data = $urandom_range(0, 65535);
    for (int i = 0; i < W; i++) begin
      exp_v = {ref_bit(w, i, 1'b1), 1'b1, i == 0, i == W-1, i == W-1};
      checks++;
      if ({serial_out, serial_valid, frame_start, done, load_ready} !== exp_v) begin
        errors++;
        $display("FAIL frame_bit word=%h i=%0d got=%b exp=%b", w, i,
                 {serial_out, serial_valid, frame_start, done, load_ready}, exp_v);
      end
      if (serial_valid) sipo = {sipo[W-2:0], serial_out};
      step();
    end
    checks++;
    if (sipo !== w) begin
      errors++; $display("FAIL loopback got=%h exp=%h", sipo, w);
    end
    checks++;
    if ({serial_valid, done, load_ready} !== 3'b001) begin
      errors++; $display("FAIL frame_end got=%b exp=001", {serial_valid, done, load_ready});
    end
  endtask

  task automatic test_back_to_back(input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sipo, cur;
    logic [4:0]   exp_v;
    exp_q = {w0, w1};
    load_data = w0; load_valid = 1'b1;
    step();
    load_data = w1;
    for (int i = 0; i < 2*W; i++) begin
      cur = exp_q[i / W];
      exp_v = {ref_bit(cur, i % W, 1'b1), 1'b1, (i % W) == 0, (i % W) == W-1, (i % W) == W-1};
      checks++;
      if ({serial_out, serial_valid, frame_start, done, load_ready} !== exp_v) begin
        errors++;
        $display("FAIL b2b_bit i=%0d got=%b exp=%b", i,
                 {serial_out, serial_valid, frame_start, done, load_ready}, exp_v);
      end
      sipo = {sipo[W-2:0], serial_out};
      if ((i % W) == W-1) begin
        checks++;
        if (sipo !== cur) begin
          errors++; $display("FAIL b2b_word i=%0d got=%h exp=%h", i, sipo, cur);
        end
      end
      step();
      if (i == W-1) load_valid = 1'b0;
    end
    checks++;
    if (serial_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end serial_valid got=%b exp=0", serial_valid);
    end
  endtask

  task automatic test_busy_rejection(input logic [W-1:0] w, input int pulse_at);
    logic [W-1:0] sipo;
    logic [4:0]   exp_v;
    load_data = w; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == pulse_at) begin
        load_valid = 1'b1; load_data = 16'h1234;
      end
      exp_v = {ref_bit(w, i, 1'b1), 1'b1, i == 0, i == W-1, i == W-1};
      checks++;
      if ({serial_out, serial_valid, frame_start, done, load_ready} !== exp_v) begin
        errors++;
        $display("FAIL busy_bit word=%h i=%0d got=%b exp=%b", w, i,
                 {serial_out, serial_valid, frame_start, done, load_ready}, exp_v);
      end
      sipo = {sipo[W-2:0], serial_out};
      step();
      load_valid = 1'b0;
    end
    checks++;
    if (sipo !== w || serial_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_result word got=%h exp=%h serial_valid got=%b exp=0", sipo, w, serial_valid);
    end
  endtask

  task automatic test_reset_mid_frame(input logic [W-1:0] w, input int reset_at);
    load_data = w; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < reset_at; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if ({serial_out, serial_valid, frame_start, done, load_ready} !== 5'b0 || state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset got=%b state=%0d exp=00000 state=0",
               {serial_out, serial_valid, frame_start, done, load_ready}, state);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_ready got=%b exp=1", load_ready);
    end
    test_single_frame(16'h00FF);
  endtask

  task automatic test_lsb_first(input logic [W-1:0] w);
    logic [W-1:0] sipo;
    logic [3:0]   exp_v;
    sipo = '0;
    lsb_data = w; lsb_valid = 1'b1;
    step();
    lsb_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      exp_v = {ref_bit(w, i, 1'b0), 1'b1, i == 0, i == W-1};
      checks++;
      if ({lsb_out, lsb_svalid, lsb_start, lsb_done} !== exp_v) begin
        errors++;
        $display("FAIL lsb_bit word=%h i=%0d got=%b exp=%b", w, i,
                 {lsb_out, lsb_svalid, lsb_start, lsb_done}, exp_v);
      end
      sipo = {lsb_out, sipo[W-1:1]};
      step();
    end
    checks++;
    if (sipo !== w || lsb_svalid !== 1'b0) begin
      errors++;
      $display("FAIL lsb_loopback got=%h exp=%h serial_valid=%b", sipo, w, lsb_svalid);
    end
  endtask

  task automatic test_idle_quiet();
    int bad;
    reset = 1'b1; step(); reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if ({serial_out, serial_valid, frame_start, done, load_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL idle_quiet cycle=%0d got=%b exp=00001", i,
                 {serial_out, serial_valid, frame_start, done, load_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(16'hA5C3);
    for (int k = 0; k < 4; k++) test_single_frame(W'($urandom_range(0, 65535)));
    test_back_to_back(16'h0001, 16'hFFFF);
    for (int k = 0; k < 3; k++)
      test_back_to_back(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)));
    test_busy_rejection(16'h8000, 5);
    for (int k = 0; k < 3; k++)
      test_busy_rejection(W'($urandom_range(0, 65535)), $urandom_range(0, W-2));
    test_reset_mid_frame(16'hFFFF, 7);
    test_reset_mid_frame(W'($urandom_range(0, 65535)), $urandom_range(0, W-1));
    test_lsb_first(16'h0003);
    for (int k = 0; k < 3; k++) test_lsb_first(W'($urandom_range(0, 65535)));
    test_idle_quiet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
